// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// -----------------------------------------------------------------------------
// Central stall/flush sequencer for the 5-stage RV32 pipeline. It drives the
// hold (stall) and bubble (flush) controls of the PC, IF/ID, ID/EX, EX/MEM and
// MEM/WB pipeline registers. It resolves, in priority order:
//   1. a data-memory access that has not completed (the whole pipeline freezes,
//      with a bounded wait),
//   2. a taken branch/jump resolved in EX (IF/ID and ID/EX are squashed),
//   3. a load-use hazard between the load in EX and the instruction in ID
//      (one bubble is inserted).
//
// Optional build feature:
//   HAZARD_PERF_CNT_EN  adds saturating performance counters stall_cycles,
//                       flush_events and loaduse_events.
//
// Parameters:
//   MEM_TIMEOUT   max cycles spent in MEM_WAIT before the access is aborted (1..255)
//   CNT_W         width of the performance counters
//
// Ports:
//   clk              pipeline clock
//   resetn           asynchronous active-low reset
//   id_rs1/id_rs2    source registers of the instruction in ID
//   id_uses_rs1/2    the ID instruction actually reads rs1/rs2
//   ex_rd            destination register of the instruction in EX
//   ex_mem_read      the EX instruction is a load
//   ex_branch_taken  EX resolved a taken branch/jump
//   mem_req          the MEM-stage instruction accesses dmem
//   dmem_ready       dmem completes the access this cycle
//   pc_stall         hold PC
//   if_id_stall      hold IF/ID
//   if_id_flush      clear IF/ID to NOP
//   id_ex_stall      hold ID/EX
//   id_ex_flush      clear ID/EX control bits
//   ex_mem_stall     hold EX/MEM
//   mem_wb_bubble    load MEM/WB with regWrite=0, memToReg=0
//   dmem_err         one-cycle pulse after a MEM_WAIT timeout
//   mem_busy         FSM is in MEM_WAIT
//   stall_cycles, flush_events, loaduse_events  (HAZARD_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
// state    | meaning
// ---------+-------------------------------------------------------------------
// IDLE     | no outstanding dmem access; a fresh un-ready request freezes now
// MEM_WAIT | dmem access outstanding; pipeline frozen until ready or timeout
// -----------------------------------------------------------------------------

module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    input  logic       ex_branch_taken,
    input  logic       mem_req,
    input  logic       dmem_ready,
    output logic       pc_stall,
    output logic       if_id_stall,
    output logic       if_id_flush,
    output logic       id_ex_stall,
    output logic       id_ex_flush,
    output logic       ex_mem_stall,
    output logic       mem_wb_bubble,
    output logic       dmem_err,
    output logic       mem_busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic [CNT_W-1:0] loaduse_events
`endif
);

    generate
        if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255 || CNT_W < 1) begin : g_param_check
            $error("pipeline_hazard_ctrl: MEM_TIMEOUT must be 1..255 and CNT_W >= 1");
        end
    endgenerate

    localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [7:0] wait_cnt;
    logic       timeout_hit;
    logic       freeze;
    logic       load_use;
    logic       br_flush;
    logic       lu_stall;

    // x0 is hardwired to zero, so a load targeting it can never feed ID.
    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    assign timeout_hit = (state == MEM_WAIT) && (wait_cnt == TIMEOUT_VAL);
    assign mem_busy    = (state == MEM_WAIT);

    // ------------------------------------------------------------------
    // Next-state and freeze decode
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        freeze     = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req && !dmem_ready) begin
                    next_state = MEM_WAIT;
                    freeze     = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    next_state = IDLE;
                end else if (timeout_hit) begin
                    next_state = IDLE;
                end else begin
                    freeze = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stall / flush outputs
    // A branch seen while frozen is simply held in the frozen EX stage; it
    // is acted on the first cycle freeze is low, so it is neither lost nor
    // applied twice. Outputs are forced low while reset is asserted even
    // though the request inputs may still be active.
    // ------------------------------------------------------------------
    always_comb begin
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_stall   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_stall  = 1'b0;
        mem_wb_bubble = 1'b0;
        br_flush      = 1'b0;
        lu_stall      = 1'b0;
        if (resetn) begin
            if (freeze) begin
                pc_stall      = 1'b1;
                if_id_stall   = 1'b1;
                id_ex_stall   = 1'b1;
                ex_mem_stall  = 1'b1;
                mem_wb_bubble = 1'b1;
            end else begin
                // The aborted MEM instruction must not write back.
                if (timeout_hit) begin
                    mem_wb_bubble = 1'b1;
                end
                if (ex_branch_taken) begin
                    // ID is squashed, so any load-use match there is moot.
                    br_flush    = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    lu_stall    = 1'b1;
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State, wait counter and error pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
            dmem_err <= 1'b0;
        end else begin
            state    <= next_state;
            dmem_err <= timeout_hit;
            if (state == IDLE && next_state == MEM_WAIT) begin
                wait_cnt <= 8'd1;
            end else if (state == MEM_WAIT && freeze) begin
                wait_cnt <= wait_cnt + 8'd1;
            end else if (next_state == IDLE) begin
                wait_cnt <= 8'd0;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    logic stall_ev;
    assign stall_ev = (freeze && resetn) || lu_stall;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cycles   <= '0;
            flush_events   <= '0;
            loaduse_events <= '0;
        end else begin
            if (stall_ev && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (br_flush && (flush_events != '1)) begin
                flush_events <= flush_events + 1'b1;
            end
            if (lu_stall && (loaduse_events != '1)) begin
                loaduse_events <= loaduse_events + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl (MEM_TIMEOUT = 4).
// Output vector order: {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
//                       id_ex_flush, ex_mem_stall, mem_wb_bubble, dmem_err, mem_busy}
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 32;

    localparam logic [8:0] E_NONE = 9'b0_0_0_0_0_0_0_0_0;
    localparam logic [8:0] E_LU   = 9'b1_1_0_0_1_0_0_0_0;
    localparam logic [8:0] E_BR   = 9'b0_0_1_0_1_0_0_0_0;
    localparam logic [8:0] E_FRZ  = 9'b1_1_0_1_0_1_1_0_0;
    localparam logic [8:0] E_FRZB = 9'b1_1_0_1_0_1_1_0_1;
    localparam logic [8:0] E_BUSY = 9'b0_0_0_0_0_0_0_0_1;
    localparam logic [8:0] E_TOUT = 9'b0_0_0_0_0_0_1_0_1;
    localparam logic [8:0] E_ERR  = 9'b0_0_0_0_0_0_0_1_0;
    localparam logic [8:0] E_BRB  = 9'b0_0_1_0_1_0_0_0_1;

    logic       clk = 1'b0;
    logic       resetn;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
    logic       mem_req, dmem_ready;
    logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic       ex_mem_stall, mem_wb_bubble, dmem_err, mem_busy;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles, flush_events, loaduse_events;
`endif

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .dmem_ready      (dmem_ready),
        .pc_stall        (pc_stall),
        .if_id_stall     (if_id_stall),
        .if_id_flush     (if_id_flush),
        .id_ex_stall     (id_ex_stall),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_stall    (ex_mem_stall),
        .mem_wb_bubble   (mem_wb_bubble),
        .dmem_err        (dmem_err),
        .mem_busy        (mem_busy)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events),
        .loaduse_events  (loaduse_events)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rstn;
        logic       mreq;
        logic       rdy;
        logic       bt;
        logic       mr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [8:0] exp;
    } vec_t;

    int         tests_run = 0;
    int         tests_failed = 0;
    logic [8:0] exp_q[$];
    string      name_q[$];

    function automatic vec_t mk(input string n, input logic rstn, input logic mreq,
                                input logic rdy, input logic bt, input logic mr,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2, input logic [8:0] e);
        vec_t v;
        v.name = n; v.rstn = rstn; v.mreq = mreq; v.rdy = rdy; v.bt = bt;
        v.mr = mr; v.rd = rd; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.exp = e;
        return v;
    endfunction

    task automatic check_out();
        logic [8:0] got;
        logic [8:0] e;
        string      n;
        got = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
               ex_mem_stall, mem_wb_bubble, dmem_err, mem_busy};
        e = exp_q.pop_front();
        n = name_q.pop_front();
        tests_run++;
        if (got !== e) begin
            tests_failed++;
            $display("FAIL %s: outputs %b, expected %b", n, got, e);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, queue the expected
    // outputs, then compare on the falling edge.
    task automatic step(input vec_t v);
        @(posedge clk);
        #1;
        resetn          = v.rstn;
        mem_req         = v.mreq;
        dmem_ready      = v.rdy;
        ex_branch_taken = v.bt;
        ex_mem_read     = v.mr;
        ex_rd           = v.rd;
        id_rs1          = v.rs1;
        id_uses_rs1     = v.u1;
        id_rs2          = v.rs2;
        id_uses_rs2     = v.u2;
        exp_q.push_back(v.exp);
        name_q.push_back(v.name);
        @(negedge clk);
        check_out();
    endtask

    task automatic chk_cnt(input string n, input logic [CNT_W-1:0] got,
                           input logic [CNT_W-1:0] e);
        tests_run++;
        if (got !== e) begin
            tests_failed++;
            $display("FAIL %s: count %0d, expected %0d", n, got, e);
        end
    endtask

    vec_t tbl[12];

    initial begin
        resetn = 1'b0;
        mem_req = 1'b0; dmem_ready = 1'b0; ex_branch_taken = 1'b0; ex_mem_read = 1'b0;
        ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;

        //             name            rstn mreq rdy bt mr  rd     rs1    u1 rs2    u2 exp
        tbl[0]  = mk("rst_req_gated",  0,   1,   0,  1, 1,  5'd5,  5'd5,  1, 5'd0,  0, E_NONE);
        tbl[1]  = mk("rst_hold",       0,   0,   0,  0, 0,  5'd0,  5'd0,  0, 5'd0,  0, E_NONE);
        tbl[2]  = mk("idle",           1,   0,   0,  0, 0,  5'd0,  5'd0,  0, 5'd0,  0, E_NONE);
        tbl[3]  = mk("lu_rs1",         1,   0,   0,  0, 1,  5'd5,  5'd5,  1, 5'd0,  0, E_LU);
        tbl[4]  = mk("lu_cleared",     1,   0,   0,  0, 0,  5'd9,  5'd5,  1, 5'd0,  0, E_NONE);
        tbl[5]  = mk("lu_x0",          1,   0,   0,  0, 1,  5'd0,  5'd0,  1, 5'd0,  1, E_NONE);
        tbl[6]  = mk("lu_rs2",         1,   0,   0,  0, 1,  5'd7,  5'd3,  1, 5'd7,  1, E_LU);
        tbl[7]  = mk("lu_rs1_unused",  1,   0,   0,  0, 1,  5'd5,  5'd5,  0, 5'd6,  1, E_NONE);
        tbl[8]  = mk("no_load",        1,   0,   0,  0, 0,  5'd5,  5'd5,  1, 5'd5,  1, E_NONE);
        tbl[9]  = mk("br_over_lu",     1,   0,   0,  1, 1,  5'd5,  5'd5,  1, 5'd0,  0, E_BR);
        tbl[10] = mk("lu_r31",         1,   0,   0,  0, 1,  5'd31, 5'd31, 1, 5'd31, 1, E_LU);
        tbl[11] = mk("zero_wait",      1,   1,   1,  0, 0,  5'd0,  5'd0,  0, 5'd0,  0, E_NONE);
        for (int i = 0; i < 12; i++) step(tbl[i]);
        step(mk("after_zero_wait", 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_NONE));

        // Memory wait: 3 un-ready cycles then ready; a load-use during freeze is masked.
        step(mk("mw_c1", 1, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_FRZ));
        step(mk("mw_c2", 1, 1, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, E_FRZB));
        step(mk("mw_c3", 1, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_FRZB));
        step(mk("mw_rdy", 1, 1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_BUSY));
        step(mk("mw_done", 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_NONE));

        // Timeout with MEM_TIMEOUT = 4.
        step(mk("to_c1", 1, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_FRZ));
        step(mk("to_c2", 1, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_FRZB));
        step(mk("to_c3", 1, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_FRZB));
        step(mk("to_c4", 1, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_FRZB));
        step(mk("to_hit", 1, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_TOUT));
        step(mk("to_err", 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_ERR));
        step(mk("to_err_gone", 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_NONE));

        // Branch held through a freeze, flushed exactly once on ready.
        step(mk("fb_c1", 1, 1, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_FRZ));
        step(mk("fb_c2", 1, 1, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_FRZB));
        step(mk("fb_rdy", 1, 1, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_BRB));
        step(mk("fb_after", 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_NONE));

        // Reset asserted while in MEM_WAIT.
        step(mk("rw_c1", 1, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_FRZ));
        step(mk("rw_c2", 1, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_FRZB));
        step(mk("rw_rst", 0, 1, 0, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0, E_NONE));
        step(mk("rw_rst2", 0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_NONE));
        step(mk("rw_rel", 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_NONE));
        step(mk("rw_no_err", 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_NONE));

`ifdef HAZARD_PERF_CNT_EN
        chk_cnt("perf_stall_rst", stall_cycles, '0);
        chk_cnt("perf_flush_rst", flush_events, '0);
        chk_cnt("perf_lu_rst", loaduse_events, '0);
        step(mk("pc_lu", 1, 0, 0, 0, 1, 5'd4, 5'd4, 1, 5'd0, 0, E_LU));
        step(mk("pc_br", 1, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_BR));
        step(mk("pc_frz", 1, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_FRZ));
        step(mk("pc_rdy", 1, 1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_BUSY));
        step(mk("pc_idle", 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_NONE));
        chk_cnt("perf_stall", stall_cycles, 32'd2);
        chk_cnt("perf_flush", flush_events, 32'd1);
        chk_cnt("perf_lu", loaduse_events, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
